// File: rtl/kpn_channel_pkg.sv
// Shared KPN channel definitions: token type and default channel depth.
package kpn_channel_pkg;

    localparam int unsigned KPN_TOKEN_WIDTH = 16;
    localparam int unsigned KPN_FIFO_DEPTH  = 8;

    typedef logic [KPN_TOKEN_WIDTH-1:0] kpn_token_t;

endpackage

// File: rtl/kpn_fifo_channel_if.sv
// Producer/consumer bus of a KPN FIFO channel; slave is the channel, master the node pair.
interface kpn_fifo_channel_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  wr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  full;
    logic                  almost_full;
    logic                  rd;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport slave (
        input  wr, data_in, rd,
        output full, almost_full, data_out, empty, count, overflow, underflow
    );

    modport master (
        output wr, data_in, rd,
        input  full, almost_full, data_out, empty, count, overflow, underflow
    );
endinterface

// File: rtl/kpn_fifo_ptr_ctrl.sv
// Pointer, occupancy and flag bookkeeping for the KPN FIFO channel.
module kpn_fifo_ptr_ctrl #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned ADDR_WIDTH     = 3,
    parameter int unsigned ALMOST_FULL_TH = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_i,
    input  logic                  rd_i,
    output logic                  push_en_c_o,
    output logic                  pop_en_c_o,
    output logic [ADDR_WIDTH-1:0] wr_ptr_o,
    output logic [ADDR_WIDTH-1:0] rd_ptr_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic                  empty_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);
    localparam int unsigned CW = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  almost_full_q, almost_full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  push_en, pop_en;

    // A full FIFO still accepts a push when the same cycle pops the head.
    assign push_en = wr_i & (~full_q | rd_i);
    assign pop_en  = rd_i & ~empty_q;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        overflow_d    = overflow_q | (wr_i & ~push_en);
        underflow_d   = underflow_q | (rd_i & empty_q);
        if (push_en) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Flags come from the next count so they line up with count_q after the edge.
        full_d        = (count_d == CW'(DEPTH));
        almost_full_d = (count_d >= CW'(ALMOST_FULL_TH));
        empty_d       = (count_d == CW'(0));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            empty_q       <= 1'b1;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            empty_q       <= empty_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    assign push_en_c_o   = push_en;
    assign pop_en_c_o    = pop_en;
    assign wr_ptr_o      = wr_ptr_q;
    assign rd_ptr_o      = rd_ptr_q;
    assign count_o       = count_q;
    assign full_o        = full_q;
    assign almost_full_o = almost_full_q;
    assign empty_o       = empty_q;
    assign overflow_o    = overflow_q;
    assign underflow_o   = underflow_q;
endmodule

// File: rtl/kpn_fifo_channel.sv
// First-word-fall-through token FIFO between one KPN producer node and one consumer node.
module kpn_fifo_channel
    import kpn_channel_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = KPN_TOKEN_WIDTH,
    parameter int unsigned DEPTH          = KPN_FIFO_DEPTH,
    parameter int unsigned ADDR_WIDTH     = $clog2(DEPTH),
    parameter int unsigned ALMOST_FULL_TH = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    kpn_fifo_channel_if.slave bus
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                  push_en;
    logic                  pop_en_unused;
    logic                  empty;

    kpn_fifo_ptr_ctrl #(
        .DEPTH          (DEPTH),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .ALMOST_FULL_TH (ALMOST_FULL_TH)
    ) u_ptr_ctrl (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .wr_i          (bus.wr),
        .rd_i          (bus.rd),
        .push_en_c_o   (push_en),
        .pop_en_c_o    (pop_en_unused),
        .wr_ptr_o      (wr_ptr),
        .rd_ptr_o      (rd_ptr),
        .count_o       (bus.count),
        .full_o        (bus.full),
        .almost_full_o (bus.almost_full),
        .empty_o       (empty),
        .overflow_o    (bus.overflow),
        .underflow_o   (bus.underflow)
    );

    // Storage is not reset; the empty flag masks stale contents.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wr_ptr] <= bus.data_in;
    end

    assign bus.empty    = empty;
    assign bus.data_out = empty ? '0 : mem_q[rd_ptr];
endmodule

// File: tb/tb_kpn_fifo_channel.sv
// Directed plus randomized check of kpn_fifo_channel against a queue-based token model.
module tb_kpn_fifo_channel;
    import kpn_channel_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned AF_TH = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kpn_fifo_channel_if #(.DATA_WIDTH(KPN_TOKEN_WIDTH), .ADDR_WIDTH(AW)) bus ();

    kpn_fifo_channel #(
        .DATA_WIDTH     (KPN_TOKEN_WIDTH),
        .DEPTH          (DEPTH),
        .ADDR_WIDTH     (AW),
        .ALMOST_FULL_TH (AF_TH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    kpn_token_t model_q[$];
    bit         m_ovf;
    bit         m_udf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = model_q.size();
        chk({tag, ".count"},       32'(bus.count),       32'(n));
        chk({tag, ".empty"},       32'(bus.empty),       32'(n == 0));
        chk({tag, ".full"},        32'(bus.full),        32'(n == DEPTH));
        chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'(n >= AF_TH));
        chk({tag, ".data_out"},    32'(bus.data_out),    (n > 0) ? 32'(model_q[0]) : 32'(0));
        chk({tag, ".overflow"},    32'(bus.overflow),    32'(m_ovf));
        chk({tag, ".underflow"},   32'(bus.underflow),   32'(m_udf));
    endtask

    // One clock: drive at negedge, update the model at the edge, compare just after it.
    task automatic step(input string tag, input logic rs, input logic w, input logic r,
                        input kpn_token_t d);
        int  sz;
        bit  push_ok, pop_ok;
        @(negedge clk);
        rst         = rs;
        bus.wr      = w;
        bus.rd      = r;
        bus.data_in = d;
        @(posedge clk);
        if (rs) begin
            model_q.delete();
            m_ovf = 0;
            m_udf = 0;
        end else begin
            sz      = model_q.size();
            pop_ok  = r && (sz > 0);
            push_ok = w && ((sz < DEPTH) || r);
            if (r && sz == 0) m_udf = 1;
            if (w && !push_ok) m_ovf = 1;
            if (pop_ok)  void'(model_q.pop_front());
            if (push_ok) model_q.push_back(d);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        rst         = 1'b1;
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        bus.data_in = '0;
        m_ovf       = 0;
        m_udf       = 0;

        // 1: reset and idle
        step("rst", 1'b1, 1'b0, 1'b0, 16'h0);
        step("rst", 1'b1, 1'b0, 1'b0, 16'h0);
        step("idle", 1'b0, 1'b0, 1'b0, 16'h0);
        chk("idle.empty_const", 32'(bus.empty), 32'(1));
        chk("idle.dout_const", 32'(bus.data_out), 32'(0));

        // 2: single token latency and pop
        step("t2.push", 1'b0, 1'b1, 1'b0, 16'hA5A5);
        chk("t2.dout_const", 32'(bus.data_out), 32'h0000_A5A5);
        step("t2.pop", 1'b0, 1'b0, 1'b1, 16'h0);
        chk("t2.empty_const", 32'(bus.empty), 32'(1));

        // 3: fill, overflow, drain in order
        for (int i = 1; i <= 8; i++) begin
            step("t3.fill", 1'b0, 1'b1, 1'b0, kpn_token_t'(i));
            if (i == 6) chk("t3.af6_const", 32'(bus.almost_full), 32'(1));
        end
        chk("t3.full_const", 32'(bus.full), 32'(1));
        step("t3.over", 1'b0, 1'b1, 1'b0, 16'hFFFF);
        chk("t3.ovf_const", 32'(bus.overflow), 32'(1));
        for (int i = 1; i <= 8; i++) begin
            chk("t3.order_const", 32'(bus.data_out), 32'(i));
            step("t3.drain", 1'b0, 1'b0, 1'b1, 16'h0);
        end

        // 4: full-throughput streaming across pointer wraps
        for (int i = 0; i < 8; i++) step("t4.fill", 1'b0, 1'b1, 1'b0, kpn_token_t'(16'h0100 + i));
        for (int i = 0; i < 20; i++) begin
            chk("t4.head_const", 32'(bus.data_out), 32'(16'h0100 + i));
            step("t4.stream", 1'b0, 1'b1, 1'b1, kpn_token_t'(16'h0108 + i));
            chk("t4.count_const", 32'(bus.count), 32'(8));
        end
        for (int i = 0; i < 8; i++) step("t4.drain", 1'b0, 1'b0, 1'b1, 16'h0);

        // 5: simultaneous wr&rd on an empty FIFO
        step("t5.wrrd", 1'b0, 1'b1, 1'b1, 16'h1234);
        chk("t5.dout_const", 32'(bus.data_out), 32'h0000_1234);
        chk("t5.udf_const", 32'(bus.underflow), 32'(1));
        step("t5.pop", 1'b0, 1'b0, 1'b1, 16'h0);

        // 6: reset mid-stream wins over wr/rd
        for (int i = 0; i < 5; i++) step("t6.fill", 1'b0, 1'b1, 1'b0, kpn_token_t'(16'h0200 + i));
        step("t6.rst", 1'b1, 1'b1, 1'b1, 16'hDEAD);
        chk("t6.count_const", 32'(bus.count), 32'(0));
        chk("t6.ovf_const", 32'(bus.overflow), 32'(0));
        chk("t6.udf_const", 32'(bus.underflow), 32'(0));
        step("t6.push", 1'b0, 1'b1, 1'b0, 16'hBEEF);
        chk("t6.head_const", 32'(bus.data_out), 32'h0000_BEEF);

        // Randomized traffic with phase-varying write/read bias and rare resets
        for (int ph = 0; ph < 8; ph++) begin
            int pw, pr;
            pw = (ph % 2 == 0) ? 75 : 35;
            pr = (ph % 2 == 0) ? 35 : 75;
            for (int i = 0; i < 50; i++) begin
                logic rs, w, r;
                rs = ($urandom_range(0, 127) == 0);
                w  = ($urandom_range(0, 99) < pw);
                r  = ($urandom_range(0, 99) < pr);
                step("rand", rs, w, r, kpn_token_t'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
